// File: rtl/sram_ctrl.sv
// Data-memory controller: each 32-bit word access becomes two 16-bit SRAM phases.
// Optional statistics counters are enabled with the SRAM_STATS_EN macro.
module sram_ctrl #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
`ifdef SRAM_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_wr_q, is_wr_d;
  logic        is_rd_q, is_rd_d;
  logic [16:0] idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [17:0] addr_q, addr_d;
  logic        we_n_q, we_n_d;
  logic        dq_oe_q, dq_oe_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic [31:0] rdata_q, rdata_d;
  logic        in_phase_d;

  logic [31:0] offset;
  logic        unused_offset_bits;

  assign offset             = address - BASE_ADDR;
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    is_rd_d = is_rd_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (rd_en | wr_en) begin
          state_d = LOW;
          cnt_d   = '0;
          is_wr_d = wr_en;
          is_rd_d = rd_en & ~wr_en;
          idx_d   = offset[18:2];
          wdata_d = write_data;
        end
      end
      LOW: begin
        if (cnt_q == LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
          if (is_rd_q) rdata_d[15:0] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HIGH: begin
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          if (is_rd_q) rdata_d[31:16] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus outputs are computed from the next state so they leave flops glitch-free;
    // WE rises one cycle before the phase ends, with address and data still held.
    in_phase_d = (state_d == LOW) || (state_d == HIGH);
    addr_d     = in_phase_d ? {idx_d, state_d == HIGH} : addr_q;
    we_n_d     = ~(in_phase_d & is_wr_d & (cnt_d != LAST));
    dq_oe_d    = in_phase_d & is_wr_d;
    dq_out_d   = (state_d == HIGH) ? wdata_d[31:16] : wdata_d[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_wr_q  <= 1'b0;
      is_rd_q  <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      addr_q   <= '0;
      we_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
      dq_out_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_wr_q  <= is_wr_d;
      is_rd_q  <= is_rd_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      addr_q   <= addr_d;
      we_n_q   <= we_n_d;
      dq_oe_q  <= dq_oe_d;
      dq_out_q <= dq_out_d;
      rdata_q  <= rdata_d;
    end
  end

`ifdef SRAM_STATS_EN
  logic [15:0] rd_count_q, wr_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else if (state_q == DONE) begin
      if (is_wr_q && wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
      if (is_rd_q && rd_count_q != 16'hFFFF) rd_count_q <= rd_count_q + 16'd1;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

  assign ready     = ~(rd_en | wr_en) | (state_q == DONE);
  assign read_data = rdata_q;
  assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
  assign SRAM_ADDR = addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: directed and random word accesses against
// a behavioural SRAM and a word-level reference memory.
module tb_sram_ctrl;
  localparam int W    = 2;
  localparam int BASE = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        ub_n, lb_n, we_n, ce_n, oe_n;
`ifdef SRAM_STATS_EN
  logic [15:0] rd_count, wr_count;
`endif

  logic        tb_drv_en = 1'b0;
  logic [15:0] tb_drv_val = '0;
  assign sram_dq = tb_drv_en ? tb_drv_val : 16'hzzzz;
  pullup (sram_dq);

  int checks = 0;
  int errors = 0;

  logic [15:0] sram_mem [int];
  logic [15:0] ref_mem  [int];
  logic [31:0] ref_rdata = '0;
  int          ref_rd = 0;
  int          ref_wr = 0;

  sram_ctrl #(.BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
`ifdef SRAM_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  always #5 clk = ~clk;

  // External chip: stores whatever is on the bus while WE is low.
  always @(negedge clk) begin
    if (!we_n) sram_mem[int'(sram_addr)] = sram_dq;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] chip_get(input logic [17:0] a);
    return sram_mem.exists(int'(a)) ? sram_mem[int'(a)] : 16'h0000;
  endfunction

  function automatic logic [15:0] ref_get(input logic [17:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000;
  endfunction

  task automatic check_stats();
`ifdef SRAM_STATS_EN
    check("rd_count", 32'(rd_count), 32'(ref_rd));
    check("wr_count", 32'(wr_count), 32'(ref_wr));
`endif
  endtask

  // One word access; rst_at >= 0 asserts reset after checking that cycle.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input int rst_at);
    logic [31:0] off;
    logic [16:0] idx;
    logic [17:0] ha;
    logic [15:0] half;
    logic        in_ph, hi;
    int          p, low_cnt;
    off     = addr - 32'(BASE);
    idx     = off[18:2];
    low_cnt = 0;
    @(negedge clk);
    rd_en = rd; wr_en = wr; address = addr; write_data = data;
    for (int k = 0; k <= 2*W+1; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) begin
        address    = $urandom;
        write_data = $urandom;
      end
      in_ph = (k >= 1) && (k <= 2*W);
      hi    = (k > W);
      p     = hi ? k - W - 1 : k - 1;
      ha    = {idx, hi};
      half  = hi ? data[31:16] : data[15:0];
      tb_drv_en  = in_ph && !wr && (p == W-1);
      tb_drv_val = chip_get(ha);
      #1;
      if (!ready) low_cnt++;
      if (in_ph) begin
        check("sram_addr", 32'(sram_addr), 32'(ha));
        check("we_n", 32'(we_n), (wr && p < W-1) ? 32'd0 : 32'd1);
        check("dq", 32'(sram_dq), wr ? 32'(half) : (tb_drv_en ? 32'(tb_drv_val) : 32'hFFFF));
      end else begin
        check("we_n_idle", 32'(we_n), 32'd1);
        check("dq_idle", 32'(sram_dq), 32'hFFFF);
      end
      if (k == 2*W+1) begin
        if (rd && !wr) ref_rdata = {ref_get({idx, 1'b1}), ref_get({idx, 1'b0})};
        check("done_ready", 32'(ready), 32'd1);
        check("read_data", read_data, ref_rdata);
      end
      if (k == rst_at) begin
        rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0; tb_drv_en = 1'b0;
        #1;
        ref_rdata = '0; ref_rd = 0; ref_wr = 0;
        check("rst_we_n", 32'(we_n), 32'd1);
        check("rst_dq", 32'(sram_dq), 32'hFFFF);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_read_data", read_data, 32'd0);
        check_stats();
        check("rst_partial_lo", 32'(chip_get({idx, 1'b0})), 32'(data[15:0]));
        ref_mem[int'({idx, 1'b0})] = data[15:0];
        ref_mem[int'({idx, 1'b1})] = chip_get({idx, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        $display("txn reset-abort wr addr=%h idx=%h", addr, idx);
        return;
      end
    end
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0; tb_drv_en = 1'b0;
    #1;
    check("ready_after", 32'(ready), 32'd1);
    check("ready_low_cycles", 32'(low_cnt), 32'(2*W+1));
    check("read_data_held", read_data, ref_rdata);
    if (wr) begin
      ref_mem[int'({idx, 1'b0})] = data[15:0];
      ref_mem[int'({idx, 1'b1})] = data[31:16];
      check("mem_lo", 32'(chip_get({idx, 1'b0})), 32'(data[15:0]));
      check("mem_hi", 32'(chip_get({idx, 1'b1})), 32'(data[31:16]));
      if (ref_wr < 65535) ref_wr++;
    end else begin
      if (ref_rd < 65535) ref_rd++;
    end
    check_stats();
    $display("txn %s addr=%h idx=%h data=%h read_data=%h",
             wr ? (rd ? "rd+wr" : "write") : "read ", addr, idx, data, read_data);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic        r, w;
    logic [31:0] a;
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_we_n", 32'(we_n), 32'd1);
    check("reset_addr", 32'(sram_addr), 32'd0);
    check("reset_read_data", read_data, 32'd0);
    check("reset_dq", 32'(sram_dq), 32'hFFFF);
    check_stats();
    @(negedge clk);
    rst_n = 1'b1;

    // Idle bus
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("idle_ready", 32'(ready), 32'd1);
      check("idle_we_n", 32'(we_n), 32'd1);
      check("idle_dq", 32'(sram_dq), 32'hFFFF);
    end

    access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, -1);
    access(1'b1, 1'b0, 32'd1024, 32'h0, -1);
    access(1'b0, 1'b1, 32'd1024 + 32'd4*32'd131071, 32'h12345678, -1);
    access(1'b0, 1'b1, 32'd1024 + 32'd4*32'd131072, 32'h12345678, -1);
    access(1'b1, 1'b0, 32'd1024, 32'h0, -1);
    access(1'b1, 1'b1, 32'd1028, 32'hCAFEF00D, -1);
    access(1'b1, 1'b0, 32'd1028, 32'h0, -1);
    access(1'b0, 1'b1, 32'd1032, 32'hA5A55A5A, W+1);
    access(1'b1, 1'b0, 32'd1032, 32'h0, -1);

    for (int i = 0; i < 30; i++) begin
      r = 1'($urandom);
      w = 1'($urandom);
      if (!r && !w) r = 1'b1;
      a = ($urandom_range(0, 3) == 0) ? $urandom : 32'(BASE) + 32'd4 * 32'($urandom_range(0, 15));
      access(r, w, a, $urandom, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
